muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage of the MIPS core.
- Sits directly upstream of the HI/LO register pair and produces its hi_write/lo_write/hi_data/lo_data write port.
- Accepts one MULT/MULTU/DIV/DIVU operation at a time and raises busy so the pipeline stalls.
- Pulses a single result-write cycle that updates both HI and LO.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO write port.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU (ops 4..7) accumulating onto {hi_in,lo_in}.
module muldiv_unit #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_ITER    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [5:0] MulLoad = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DivLast = 6'(DIV_ITER);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] a_q, b_q;
  logic        signed_q;
  logic [31:0] quot_q, rem_q, dvs_q;
  logic        quot_neg_q, rem_neg_q;

  logic        op_legal, op_is_div;
  logic [63:0] mul_a, mul_b, prod, mul_res;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, quot_nx;
  logic [31:0] quot_fix, rem_fix;

`ifdef MULDIV_MADD_EN
  logic        acc_en_q, acc_sub_q;
  logic [63:0] acc_q;
  assign op_legal = 1'b1;
`else
  logic unused_acc;
  assign unused_acc = ^{hi_in, lo_in};
  assign op_legal = ~op[2];
`endif

  assign op_is_div = ~op[2] & op[1];

  always_comb begin
    mul_a = {{32{signed_q & a_q[31]}}, a_q};
    mul_b = {{32{signed_q & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
    mul_res = prod;
`ifdef MULDIV_MADD_EN
    if (acc_en_q) mul_res = acc_sub_q ? (acc_q - prod) : (acc_q + prod);
`endif
  end

  // One restoring step: the dividend shifts out of quot_q as quotient bits shift in.
  always_comb begin
    rem_sh  = {rem_q, quot_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    rem_nx  = diff[32] ? rem_sh[31:0] : diff[31:0];
    quot_nx = {quot_q[30:0], ~diff[32]};
    quot_fix = quot_neg_q ? (32'd0 - quot_q) : quot_q;
    rem_fix  = rem_neg_q ? (32'd0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      signed_q   <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_en_q   <= 1'b0;
      acc_sub_q  <= 1'b0;
      acc_q      <= '0;
`endif
    end else if (flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start && op_legal) begin
            busy_q     <= 1'b1;
            a_q        <= a;
            b_q        <= b;
            signed_q   <= ~op[0];
            quot_q     <= (~op[0] & a[31]) ? (32'd0 - a) : a;
            dvs_q      <= (~op[0] & b[31]) ? (32'd0 - b) : b;
            rem_q      <= '0;
            quot_neg_q <= ~op[0] & (a[31] ^ b[31]);
            rem_neg_q  <= ~op[0] & a[31];
`ifdef MULDIV_MADD_EN
            acc_en_q   <= op[2];
            acc_sub_q  <= op[1];
            acc_q      <= {hi_in, lo_in};
`endif
            if (op_is_div) begin
              state_q <= StDiv;
              cnt_q   <= '0;
            end else begin
              state_q <= StMul;
              cnt_q   <= MulLoad;
            end
          end
        end
        StMul: begin
          if (cnt_q == '0) begin
            hi_q    <= mul_res[63:32];
            lo_q    <= mul_res[31:0];
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        StDiv: begin
          if (cnt_q == DivLast) begin
            // Divide by zero still runs the full latency; result is forced here.
            if (dvs_q == '0) begin
              hi_q <= a_q;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Flush must kill the write in the same cycle, so it bypasses the register.
  assign done     = done_q & ~flush;
  assign hi_write = done;
  assign lo_write = done;
  assign busy     = busy_q;
  assign hi_data  = hi_q;
  assign lo_data  = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned ML = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0, hi_in = '0, lo_in = '0;
  logic        busy, done, hi_write, lo_write;
  logic [31:0] hi_data, lo_data;

  int nchk = 0;
  int nerr = 0;

  muldiv_unit #(.MUL_LATENCY(ML), .DIV_ITER(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {hi, lo} as the architecture defines it.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] h,
                                        input logic [31:0] l);
    logic [63:0] p;
    int sx, sy;
    if (o == 3'd2 || o == 3'd3) begin
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (o == 3'd3) return {x % y, x / y};
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sx = $signed(x);
      sy = $signed(y);
      return {32'(sx % sy), 32'(sx / sy)};
    end
    if (o[0]) p = {32'd0, x} * {32'd0, y};
    else      p = 64'(longint'($signed(x)) * longint'($signed(y)));
    if (o[2]) p = o[1] ? ({h, l} - p) : ({h, l} + p);
    return p;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  // Start an op, hold start high with junk operands meanwhile, check latency, data and writes.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] h, input logic [31:0] l,
                        input logic [63:0] exp);
    int e;
    int lat;
    logic busy_ok;
    lat = (o == 3'd2 || o == 3'd3) ? 33 : int'(ML);
    op = o; a = x; b = y; hi_in = h; lo_in = l; start = 1'b1;
    step();
    a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
    e = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && e < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      e++;
    end
    check({tag, " latency"}, 64'(e), 64'(lat));
    check({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " data"}, {hi_data, lo_data}, exp);
    check({tag, " writes"}, {61'd0, busy, hi_write, lo_write}, 64'd7);
    start = 1'b0;
    step();
    check({tag, " idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (done === 1'b1 || hi_write === 1'b1) cnt++;
      step();
    end
  endtask

  initial begin
    int e;
    int nd;
    logic [2:0] ro;
    logic [31:0] rx, ry, rh, rl;

    repeat (3) step();
    check("reset ctrl", {60'd0, busy, done, hi_write, lo_write}, 64'd0);
    check("reset data", {hi_data, lo_data}, 64'd0);
    resetn = 1'b1;
    step();

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0001);
    run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7, 0, 0, {32'd2, 32'd14});
    run_op("divu by0", 3'd3, 32'h1234_5678, 32'd0, 0, 0, {32'h1234_5678, 32'hFFFF_FFFF});
    run_op("div by0", 3'd2, 32'hFFFF_FFFB, 32'd0, 0, 0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, {32'd0, 32'h8000_0000});

    // Flush mid-divide at cycle 10, then an immediate new op must be accepted.
    op = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    #1;
    check("flush div write", {62'd0, hi_write, lo_write}, 64'd0);
    step();
    flush = 1'b0;
    check("flush div idle", {62'd0, busy, done}, 64'd0);
    run_op("after flush", 3'd3, 32'd50, 32'd6, 0, 0, {32'd2, 32'd8});

    // Flush arriving in the done cycle suppresses the write.
    op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    e = 0;
    while (done !== 1'b1 && e < 40) begin
      step();
      e++;
    end
    check("flush done reached", 64'(e), 64'(ML));
    flush = 1'b1;
    #1;
    check("flush done suppress", {61'd0, done, hi_write, lo_write}, 64'd0);
    step();
    flush = 1'b0;
    check("flush done idle", {63'd0, busy}, 64'd0);
    count_dones(5, nd);
    check("flush done no write", 64'(nd), 64'd0);

    // Synchronous reset mid-divide discards the op.
    op = 3'd3; a = 32'd77; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    resetn = 1'b0;
    step();
    check("reset mid ctrl", {62'd0, busy, done}, 64'd0);
    check("reset mid data", {hi_data, lo_data}, 64'd0);
    resetn = 1'b1;
    count_dones(40, nd);
    check("reset mid no write", 64'(nd), 64'd0);

`ifdef MULDIV_MADD_EN
    run_op("msub", 3'd6, 32'd3, 32'd4, 32'd0, 32'd10, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    op = 3'd4; a = 32'd3; b = 32'd4; start = 1'b1;
    step();
    step();
    check("illegal op busy", {63'd0, busy}, 64'd0);
    start = 1'b0;
    count_dones(10, nd);
    check("illegal op no write", 64'(nd), 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef MULDIV_MADD_EN
      ro = 3'($urandom_range(0, 7));
`else
      ro = 3'($urandom_range(0, 3));
`endif
      rx = pick_operand();
      ry = pick_operand();
      rh = $urandom;
      rl = $urandom;
      run_op($sformatf("rand%0d op%0d", i, ro), ro, rx, ry, rh, rl, model(ro, rx, ry, rh, rl));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
